// File: rtl/ps2_key_scheduler_pkg.sv
// Shared constants, FSM encoding and the latched key-event record used by the
// PS/2 key scheduler and its round-robin arbiter.
package ps2_key_scheduler_pkg;

   // Scan-code prefixes emitted ahead of the base code.
   localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
   localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

   // Scheduler FSM encoding.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_SEND  = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   // Bytes still owed for the event being transmitted. A set flag means the
   // corresponding byte has not been sent yet; prefixes go out before the code.
   typedef struct packed {
      logic       ext;
      logic       rel;
      logic       code_pend;
      logic [7:0] code;
   } key_event_t;

   localparam key_event_t KEY_EVENT_NONE = '0;

   // Next byte to transmit for an event: E0 first, then F0, then the base code.
   function automatic logic [7:0] event_head(input key_event_t ev);
      if (ev.ext)
         return PS2_EXT_PREFIX;
      else if (ev.rel)
         return PS2_BREAK_PREFIX;
      else
         return ev.code;
   endfunction

   // The same event with its head byte marked as sent.
   function automatic key_event_t event_pop(input key_event_t ev);
      key_event_t rest;
      rest = ev;
      if (ev.ext)
         rest.ext = 1'b0;
      else if (ev.rel)
         rest.rel = 1'b0;
      else
         rest.code_pend = 1'b0;
      return rest;
   endfunction

   // True while at least one byte of the event remains to be sent.
   function automatic logic event_pending(input key_event_t ev);
      return ev.ext | ev.rel | ev.code_pend;
   endfunction

endpackage

// File: rtl/ps2_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1
// (wrapping at N_REQ) and picks the first active requester.
module ps2_rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] last_grant,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] index,
   output logic                     valid
);

   localparam int IW = $clog2(N_REQ);

   // Candidate position before the mod-N_REQ fold; one spare bit keeps
   // last_grant + N_REQ from overflowing.
   logic [IW:0]   sum;
   logic [IW-1:0] cand;

   // Walk the rotated priority order, first hit wins.
   always_comb begin
      // NOTE: every output and temporary gets a default before the loop so no
      // path leaves a value unassigned, which would infer a latch.
      grant = '0;
      index = '0;
      valid = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         sum = {1'b0, last_grant} + (IW+1)'(off);
         if (sum >= (IW+1)'(N_REQ))
            sum = sum - (IW+1)'(N_REQ);
         cand = sum[IW-1:0];
         if (!valid && req[cand]) begin
            valid       = 1'b1;
            index       = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_key_scheduler.sv
// Serialises key events from N_REQ requesters into PS/2 scan-code bytes for a
// keyboard model: one key_action pulse per byte, exactly GAP_CYCLES apart
// within an event, and a return through IDLE between events.
module ps2_key_scheduler
   import ps2_key_scheduler_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int GAP_CYCLES = 80
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   req_code,
   input  logic [N_REQ-1:0]     req_ext,
   input  logic [N_REQ-1:0]     req_rel,
   output logic [N_REQ-1:0]     ack,
   output logic                 key_action,
   output logic [7:0]           scan_code,
   output logic                 busy
);

   localparam int IW = $clog2(N_REQ);
   localparam int GW = $clog2(GAP_CYCLES) + 1;
   // Last count value of a gap; the gap spans counts 1..GAP_CYCLES-1.
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [IW-1:0]    last_grant;
   logic [GW-1:0]    gap_cnt;
   key_event_t       cur_ev;
   key_event_t       win_ev;
   key_event_t       src_ev;
   logic [N_REQ-1:0] arb_grant;
   logic [IW-1:0]    arb_index;
   logic             arb_valid;
   logic             gap_done;

   ps2_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arbiter (
      .req        (req),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .index      (arb_index),
      .valid      (arb_valid)
   );

   // Event offered by the arbitration winner, sampled only in GRANT.
   always_comb begin
      win_ev           = KEY_EVENT_NONE;
      win_ev.ext       = req_ext[arb_index];
      win_ev.rel       = req_rel[arb_index];
      win_ev.code_pend = 1'b1;
      win_ev.code      = req_code[{arb_index, 3'b000} +: 8];
   end

   // Byte source: the fresh winner on the first byte, the latched remainder after.
   assign src_ev = (state == ST_GRANT) ? win_ev : cur_ev;

   // With a one-cycle spacing there is no gap phase at all.
   assign gap_done = (GAP_CYCLES <= 1) ? 1'b1 : (gap_cnt == GAP_LAST);

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (|req) state_nxt = ST_GRANT;
         // A requester that dropped its req before being acked leaves nothing to
         // serve, so GRANT falls back to IDLE without an ack.
         ST_GRANT: state_nxt = arb_valid ? ST_SEND : ST_IDLE;
         ST_SEND: begin
            if (GAP_CYCLES > 1)
               state_nxt = ST_GAP;
            else
               state_nxt = event_pending(cur_ev) ? ST_SEND : ST_IDLE;
         end
         ST_GAP:   if (gap_done) state_nxt = event_pending(cur_ev) ? ST_SEND : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Round-robin pointer; starts at N_REQ-1 so requester 0 is first in line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_grant <= IW'(N_REQ - 1);
      else if (state == ST_GRANT && arb_valid)
         last_grant <= arb_index;
   end

   // Load the outgoing byte and keep the rest of the event, on every entry to SEND.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_ev    <= KEY_EVENT_NONE;
         scan_code <= 8'h00;
      end else if (state_nxt == ST_SEND) begin
         cur_ev    <= event_pop(src_ev);
         scan_code <= event_head(src_ev);
      end
   end

   // Gap counter: 1 on entry to GAP, cleared whenever GAP is left.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         gap_cnt <= '0;
      else if (state_nxt == ST_GAP)
         gap_cnt <= (state == ST_GAP) ? gap_cnt + GW'(1) : GW'(1);
      else
         gap_cnt <= '0;
   end

   // Outputs decode straight from state, so reset clears them at once.
   assign ack        = (state == ST_GRANT) ? arb_grant : '0;
   assign key_action = (state == ST_SEND);
   assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_key_scheduler.sv
// Bench for ps2_key_scheduler: directed scenarios plus randomized requesters,
// checked by a scoreboard that predicts winners and byte streams from the
// round-robin and prefix rules.
module tb_ps2_key_scheduler;

   localparam int N   = 4;
   localparam int GAP = 80;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_code;
   logic [N-1:0]   req_ext;
   logic [N-1:0]   req_rel;
   logic [N-1:0]   ack;
   logic           key_action;
   logic [7:0]     scan_code;
   logic           busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ps2_key_scheduler #(
      .N_REQ      (N),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_code   (req_code),
      .req_ext    (req_ext),
      .req_rel    (req_rel),
      .ack        (ack),
      .key_action (key_action),
      .scan_code  (scan_code),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard state (written only by the monitor) --------
   int         cyc = 0;
   logic [7:0] exp_q[$];
   int         ack_order[$];
   int         ptr;
   int         ack_cyc;
   int         last_pulse;
   int         end_cyc;
   bit         have_last;
   bit         first_byte;
   logic [7:0] model_scan;
   int         ack_cnt[N];
   int         pulses = 0;
   logic [N-1:0] acked = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (reset) begin
         check("rst_ack", ack, '0);
         check("rst_key_action", key_action, 0);
         check("rst_scan_code", scan_code, 8'h00);
         check("rst_busy", busy, 0);
         exp_q.delete();
         ptr        = N - 1;
         model_scan = 8'h00;
         have_last  = 1'b0;
         first_byte = 1'b0;
         end_cyc    = -100000;
         acked      = '0;
      end else begin
         acked = ack;
         if (ack != '0) begin
            int w;
            int exp_w;
            check("ack_onehot", $onehot(ack), 1);
            check("ack_with_key_action", key_action, 0);
            check("ack_busy", busy, 1);
            check("ack_before_prev_done", exp_q.size(), 0);
            exp_w = -1;
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (ptr + k) % N;
               if (exp_w < 0 && req[c]) exp_w = c;
            end
            w = 0;
            for (int k = N - 1; k >= 0; k--) if (ack[k]) w = k;
            check("ack_winner", w, exp_w);
            if (exp_w >= 0) begin
               if (req_ext[exp_w]) exp_q.push_back(8'hE0);
               if (req_rel[exp_w]) exp_q.push_back(8'hF0);
               exp_q.push_back(req_code[8*exp_w +: 8]);
               ptr = exp_w;
            end
            ack_cnt[w]++;
            ack_order.push_back(w);
            ack_cyc    = cyc;
            first_byte = 1'b1;
         end
         if (key_action) begin
            pulses++;
            check("key_busy", busy, 1);
            check("key_expected", exp_q.size() > 0, 1);
            if (first_byte) begin
               check("ack_to_first_byte", cyc - ack_cyc, 1);
               if (have_last) check("event_spacing_min", (cyc - last_pulse) >= GAP + 2, 1);
            end else if (have_last) begin
               check("byte_spacing", cyc - last_pulse, GAP);
            end
            if (exp_q.size() > 0) begin
               model_scan = exp_q.pop_front();
               check("scan_code_byte", scan_code, model_scan);
               if (exp_q.size() == 0) end_cyc = cyc;
            end else begin
               model_scan = scan_code;
            end
            first_byte = 1'b0;
            have_last  = 1'b1;
            last_pulse = cyc;
         end else begin
            check("scan_code_hold", scan_code, model_scan);
            if (exp_q.size() == 0 && ack == '0) begin
               if (cyc - end_cyc == GAP - 1) check("busy_in_last_gap", busy, 1);
               if (cyc - end_cyc == GAP) check("idle_after_gap", busy, 0);
            end
         end
      end
   end

   // ---------------- stimulus helpers --------------------------------------
   // Advance one cycle; a requester withdraws its req right after its ack.
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acked[i]) req[i] = 1'b0;
   endtask

   task automatic raise(input int i, input logic [7:0] code, input logic ext, input logic rel);
      req_code[8*i +: 8] = code;
      req_ext[i]         = ext;
      req_rel[i]         = rel;
      req[i]             = 1'b1;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n;
      n = 0;
      while ((busy || req != '0) && n < budget) begin
         step();
         n++;
      end
      check({tag, "_idle_in_time"}, n < budget, 1);
   endtask

   task automatic do_reset();
      req    = '0;
      reset  = 1'b1;
      repeat (3) step();
      reset  = 1'b0;
      step();
   endtask

   // ---------------- test sequence -----------------------------------------
   initial begin
      int t0;
      int p0;
      int a1;
      int a3;
      int n;

      reset    = 1'b1;
      req      = '0;
      req_code = '0;
      req_ext  = '0;
      req_rel  = '0;
      repeat (3) step();
      reset = 1'b0;
      step();
      check("post_reset_busy", busy, 0);
      check("post_reset_scan", scan_code, 8'h00);

      // Single plain make code.
      p0 = pulses;
      raise(0, 8'h1C, 1'b0, 1'b0);
      t0 = cyc;
      wait_idle(400, "plain");
      check("plain_ack_latency", ack_cyc - t0, 1);
      check("plain_acks", ack_cnt[0], 1);
      check("plain_pulses", pulses - p0, 1);
      check("plain_scan", scan_code, 8'h1C);

      // Extended release: E0 F0 75 from requester 2.
      p0 = pulses;
      raise(2, 8'h75, 1'b1, 1'b1);
      wait_idle(600, "ext_rel");
      check("ext_rel_acks", ack_cnt[2], 1);
      check("ext_rel_pulses", pulses - p0, 3);
      check("ext_rel_scan", scan_code, 8'h75);

      // Code change one cycle after ack must not alter the latched byte.
      a1 = ack_cnt[1];
      raise(1, 8'h1C, 1'b0, 1'b0);
      n = 0;
      while (ack_cnt[1] == a1 && n < 50) begin step(); n++; end
      check("latch_ack_seen", ack_cnt[1] - a1, 1);
      req_code[15:8] = 8'h32;
      wait_idle(400, "latch");
      check("latch_scan", scan_code, 8'h1C);

      // All four at once after reset: served 0,1,2,3, code 00 forwarded.
      do_reset();
      ack_order.delete();
      p0 = pulses;
      raise(0, 8'h00, 1'b0, 1'b0);
      raise(1, 8'h11, 1'b1, 1'b0);
      raise(2, 8'h22, 1'b0, 1'b1);
      raise(3, 8'h33, 1'b1, 1'b1);
      wait_idle(2000, "all4");
      check("all4_ack_count", ack_order.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < ack_order.size()) check($sformatf("all4_order_%0d", k), ack_order[k], k);
      check("all4_pulses", pulses - p0, 8);

      // Requester 3 pulses for one cycle while busy: dropped, 1 still served.
      a1 = ack_cnt[1];
      a3 = ack_cnt[3];
      p0 = pulses;
      raise(1, 8'h2B, 1'b0, 1'b1);
      n = 0;
      while (pulses == p0 && n < 50) begin step(); n++; end
      check("drop_busy_seen", busy, 1);
      raise(3, 8'h4D, 1'b0, 1'b0);
      step();
      req[3] = 1'b0;
      wait_idle(600, "drop");
      check("drop_acks_3", ack_cnt[3] - a3, 0);
      check("drop_acks_1", ack_cnt[1] - a1, 1);
      check("drop_pulses", pulses - p0, 2);

      // Reset between F0 and the code byte abandons the event.
      p0 = pulses;
      raise(0, 8'h5A, 1'b1, 1'b1);
      n = 0;
      while (pulses - p0 < 2 && n < 400) begin step(); n++; end
      check("midrst_two_bytes", pulses - p0, 2);
      repeat (10) step();
      reset = 1'b1;
      #1;
      check("midrst_key_action", key_action, 0);
      check("midrst_scan", scan_code, 8'h00);
      check("midrst_busy", busy, 0);
      check("midrst_ack", ack, '0);
      step();
      step();
      reset = 1'b0;
      p0 = pulses;
      repeat (300) step();
      check("midrst_no_more_bytes", pulses - p0, 0);
      check("midrst_idle", busy, 0);

      // Randomized requesters, including some that give up before their ack.
      for (int c = 0; c < 6000; c++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (!req[i] && !acked[i] && $urandom_range(0, 39) == 0)
               raise(i, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (req[i] && !acked[i] && $urandom_range(0, 299) == 0)
               req[i] = 1'b0;
         end
      end
      wait_idle(3000, "rand_drain");
      check("rand_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_key_scheduler.md
PS2_KEY_SCHEDULER -- requirements
Module: ps2_key_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of key requesters (2..8).
REQ-002 SHALL have parameter GAP_CYCLES, default 80, meaning clk cycles between successive key_action pulses (>=1; 80 covers one 11-bit PS/2 frame at clk/6).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  N_REQ  per-requester key event request, level, held until ack.
REQ-006 SHALL have port req_code  input  8*N_REQ  base scan code; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port req_ext  input  N_REQ  1 = extended key, needs E0 prefix.
REQ-008 SHALL have port req_rel  input  N_REQ  1 = release (break) event, needs F0 prefix.
REQ-009 SHALL have port ack  output  N_REQ  one-cycle pulse, one-hot, event accepted.
REQ-010 SHALL have port key_action  output  1  one-cycle pulse, scan_code valid, drives keyboard model.
REQ-011 SHALL have port scan_code  output  8  byte to enqueue into keyboard model.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, SEND, GAP.
REQ-014 IDLE: if any req bit high, go to GRANT next cycle; else stay.
REQ-015 GRANT: select winner round-robin starting at index (last_grant+1) mod N_REQ; latch its code/ext/rel; pulse ack[winner]; update last_grant; go to SEND.
REQ-016 Byte sequence per event: [E0 if ext], [F0 if rel], code; order E0 before F0; length 1..3 bytes.
REQ-017 SEND: key_action=1 for exactly one cycle with scan_code = current sequence byte; go to GAP.
REQ-018 GAP: count GAP_CYCLES-1 further cycles, so consecutive key_action pulses are exactly GAP_CYCLES cycles apart; then SEND if bytes remain, else IDLE.
REQ-019 After last byte's gap, IDLE SHALL be entered before any new arbitration; minimum spacing between the last byte of one event and the first byte of the next is GAP_CYCLES+2 cycles.
REQ-020 req/code/ext/rel changes after ack SHALL NOT affect the latched event.
REQ-021 A req deasserted before its ack SHALL be dropped without output.
REQ-022 Simultaneous requests: exactly one ack per GRANT; losers keep waiting; no requester is skipped while its req stays high (starvation-free within N_REQ events).
REQ-023 scan_code SHALL hold its last value between pulses; code 8'h00 is forwarded like any other.
REQ-024 ack and key_action SHALL never be high in the same cycle.
REQ-025 Gap counter width SHALL be clog2(GAP_CYCLES)+1; no wrap within a gap.

Reset
REQ-026 reset high SHALL immediately force: state IDLE, ack=0, key_action=0, scan_code=8'h00, busy=0, last_grant=N_REQ-1 (so requester 0 wins first), gap counter 0, latched event cleared.
REQ-027 Reset mid-sequence SHALL abandon remaining bytes; no partial sequence resumes after release.

Structure
REQ-028 Shared package SHALL hold constants PS2_EXT_PREFIX=8'hE0, PS2_BREAK_PREFIX=8'hF0 and the FSM state encoding.
REQ-029 Round-robin arbiter SHALL be a sub-module ps2_rr_arbiter (inputs req, last_grant; output one-hot grant, index).
REQ-030 Output ports SHALL connect directly to keyboard model key_action/scan_code with Resetn = ~reset.

Verification
REQ-031 req[0]=1, code 8'h1C, ext=0, rel=0 -> ack[0] 1 cycle after req, key_action one pulse with 8'h1C 1 cycle later, busy low after GAP_CYCLES more.
REQ-032 req[2]=1, code 8'h75, ext=1, rel=1 -> bytes E0, F0, 75 exactly 80 cycles apart, single ack[2].
REQ-033 req=4'b1111 simultaneously after reset, all held -> acks in order 0,1,2,3, each followed by its byte sequence.
REQ-034 req[1] held, req[3] pulsed for 1 cycle while busy -> requester 3 produces no ack and no output; requester 1 served.
REQ-035 reset asserted between F0 and code bytes of an ext+rel event -> key_action stays 0, scan_code=00, busy=0; after release no further bytes.
REQ-036 Change req_code from 8'h1C to 8'h32 one cycle after ack -> output byte remains 8'h1C.
